// File: rtl/instr_sequencer_if.sv
// -----------------------------------------------------------------------------
// instr_sequencer_if
//   Bundles the sequencer's control, instruction-memory and data-memory
//   signals so the sequencer and its environment connect through one port.
//
//   master modport (sequencer side)
//     in : start, im_ack, im_data, status, dm_ack
//     out: im_req, im_addr, opcode, literal, exec_en, dm_req, pc, halted
//   slave modport (environment side): the same signals, directions reversed.
// -----------------------------------------------------------------------------
interface instr_sequencer_if #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned OP_W  = 7,
  parameter int unsigned LIT_W = 8
);
  localparam int unsigned IW = OP_W + LIT_W;

  logic              start;
  logic              im_req;
  logic [PC_W-1:0]   im_addr;
  logic              im_ack;
  logic [IW-1:0]     im_data;
  logic [OP_W-1:0]   opcode;
  logic [LIT_W-1:0]  literal;
  logic              exec_en;
  logic [3:0]        status;
  logic              dm_req;
  logic              dm_ack;
  logic [PC_W-1:0]   pc;
  logic              halted;

  modport master (
    input  start, im_ack, im_data, status, dm_ack,
    output im_req, im_addr, opcode, literal, exec_en, dm_req, pc, halted
  );

  modport slave (
    output start, im_ack, im_data, status, dm_ack,
    input  im_req, im_addr, opcode, literal, exec_en, dm_req, pc, halted
  );
endinterface

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//   Multi-cycle fetch/decode/execute sequencer for the accumulator CPU.
//   Owns PC, the instruction register and the jump flags; handshakes with
//   instruction memory (im_req/im_ack) and data memory (dm_req/dm_ack);
//   emits a one-cycle exec_en commit strobe per ALU/MEM instruction.
//
//   Ports
//     clk    : rising-edge clock
//     reset  : asynchronous, active-high
//     bus    : instr_sequencer_if.master
//              start            leave IDLE and begin fetching at pc
//              im_req/im_addr   instruction fetch request / address (= pc)
//              im_ack/im_data   fetch complete / instruction word
//              opcode/literal   IR fields to decoder / datapath
//              exec_en          commit strobe
//              status           live ALU flags {V,C,N,Z}
//              dm_req/dm_ack    data-memory request / complete
//              pc               current program counter
//              halted           HALT executed
// -----------------------------------------------------------------------------
module instr_sequencer #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned OP_W  = 7,
  parameter int unsigned LIT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  instr_sequencer_if.master   bus
);
  localparam int unsigned IW = OP_W + LIT_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [3:0] CLASS_MEM = 4'b0101;
  localparam logic [3:0] CLASS_JMP = 4'b1001;

  logic [2:0]       state_q, state_d;
  logic [PC_W-1:0]  pc_q,    pc_d;
  logic [IW-1:0]    ir_q,    ir_d;
  logic [3:0]       flags_q, flags_d;

  logic [OP_W-1:0]  op;
  logic [LIT_W-1:0] lit;
  logic             is_mem, is_jmp, is_halt;
  logic             jmp_taken;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  jmp_target;

  // Only Z and C steer jumps; N and V are kept in the flags register so the
  // whole status word is captured, but nothing reads them here.
  logic             unused_flags;
  assign unused_flags = flags_q[1] ^ flags_q[3];

  // ---------------------------------------------------------------------------
  // Instruction field decode (driven from the latched IR, never im_data)
  // ---------------------------------------------------------------------------
  assign op      = ir_q[IW-1 -: OP_W];
  assign lit     = ir_q[LIT_W-1:0];
  assign is_halt = (op == {OP_W{1'b1}});
  assign is_mem  = (op[OP_W-1 -: 4] == CLASS_MEM);
  assign is_jmp  = (op[OP_W-1 -: 4] == CLASS_JMP);

  assign pc_inc     = pc_q + PC_W'(1);
  assign jmp_target = lit[PC_W-1:0];

  // Jump conditions use the flags latched at the last ALU EXEC, not status.
  always_comb begin
    jmp_taken = 1'b0;
    case (op[2:0])
      3'b000:  jmp_taken = 1'b1;         // JMP
      3'b001:  jmp_taken = flags_q[0];   // JEQ
      3'b010:  jmp_taken = ~flags_q[0];  // JNE
      3'b011:  jmp_taken = flags_q[2];   // JCS
      default: jmp_taken = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    flags_d = flags_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_FETCH;
      end

      S_FETCH: begin
        if (bus.im_ack) begin
          ir_d    = bus.im_data;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        if (is_halt)     state_d = S_HALT;
        else if (is_mem) state_d = S_MEM;
        else             state_d = S_EXEC;
      end

      S_EXEC: begin
        if (is_jmp) begin
          pc_d = jmp_taken ? jmp_target : pc_inc;
        end else begin
          flags_d = bus.status;
          pc_d    = pc_inc;
        end
        state_d = S_FETCH;
      end

      S_MEM: begin
        if (bus.dm_ack) begin
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all state-decoded so reset clears requests in the same cycle.
  // exec_en in MEM follows dm_ack combinationally so the commit lines up with
  // the completing data-memory cycle.
  // ---------------------------------------------------------------------------
  assign bus.im_req  = (state_q == S_FETCH);
  assign bus.im_addr = pc_q;
  assign bus.opcode  = op;
  assign bus.literal = lit;
  assign bus.dm_req  = (state_q == S_MEM);
  assign bus.exec_en = ((state_q == S_EXEC) && !is_jmp) ||
                       ((state_q == S_MEM)  && bus.dm_ack);
  assign bus.pc      = pc_q;
  assign bus.halted  = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
//   Directed self-checking bench for instr_sequencer. Inputs change 1 ns after
//   the rising edge; outputs are checked in that same window.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;
  logic clk;
  logic reset;

  instr_sequencer_if #(.PC_W(8), .OP_W(7), .LIT_W(8)) bus ();

  instr_sequencer #(.PC_W(8), .OP_W(7), .LIT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests;
  int unsigned n_fail;

  logic [14:0] prog [0:2];

  function automatic logic [14:0] w(input logic [6:0] op, input logic [7:0] k);
    return {op, k};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Runs one ALU/JMP instruction starting in FETCH; ends back in FETCH.
  // st is the live status during EXEC; spur drives acks in DECODE/EXEC with a
  // HALT word on im_data that must not be latched.
  task automatic run_instr(input string tag, input logic [6:0] op, input logic [7:0] k,
                           input logic [3:0] st, input bit spur, input bit exp_exec);
    bus.im_data = w(op, k);
    bus.im_ack  = 1'b1;
    tick();                                   // DECODE
    bus.im_ack  = spur;
    bus.dm_ack  = spur;
    if (spur) bus.im_data = w(7'h7F, 8'h00);
    check({tag, "_dec_op"}, 32'(bus.opcode), 32'(op));
    check({tag, "_dec_exec"}, 32'(bus.exec_en), 32'd0);
    tick();                                   // EXEC
    bus.status = st;
    #1;
    check({tag, "_exec_en"}, 32'(bus.exec_en), 32'(exp_exec));
    check({tag, "_exec_op"}, 32'(bus.opcode), 32'(op));
    tick();                                   // FETCH
    bus.im_ack = 1'b0;
    bus.dm_ack = 1'b0;
    check({tag, "_fetch_req"}, 32'(bus.im_req), 32'd1);
    check({tag, "_halted"}, 32'(bus.halted), 32'd0);
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.im_ack  = 1'b0;
    bus.im_data = '0;
    bus.status  = '0;
    bus.dm_ack  = 1'b0;
    prog[0] = w(7'h02, 8'h05);
    prog[1] = w(7'h04, 8'h00);
    prog[2] = w(7'h7F, 8'h00);

    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_im_req",  32'(bus.im_req),  32'd0);
    check("rst_exec_en", 32'(bus.exec_en), 32'd0);
    check("rst_dm_req",  32'(bus.dm_req),  32'd0);
    check("rst_halted",  32'(bus.halted),  32'd0);
    check("rst_opcode",  32'(bus.opcode),  32'd0);
    check("rst_literal", 32'(bus.literal), 32'd0);
    check("rst_pc",      32'(bus.pc),      32'd0);
    reset = 1'b0;
    tick();
    check("idle_no_req", 32'(bus.im_req), 32'd0);

    // ---------------- reset mid-FETCH ----------------
    bus.start = 1'b1;
    tick();                                   // FETCH @0
    bus.start = 1'b0;
    check("f0_req",  32'(bus.im_req),  32'd1);
    check("f0_addr", 32'(bus.im_addr), 32'h00);
    run_instr("pre_alu", 7'h02, 8'h05, 4'h0, 1'b0, 1'b1);
    check("pre_pc", 32'(bus.im_addr), 32'h01);
    tick();                                   // still FETCH, no ack
    check("hold_req", 32'(bus.im_req), 32'd1);
    #3 reset = 1'b1;
    #1;
    check("midrst_req",    32'(bus.im_req), 32'd0);
    check("midrst_pc",     32'(bus.pc),     32'h00);
    check("midrst_opcode", 32'(bus.opcode), 32'h00);
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_idle", 32'(bus.im_req), 32'd0);
    bus.start = 1'b1;
    tick();                                   // FETCH @0 (cycle 1)
    bus.start = 1'b0;
    check("restart_req",  32'(bus.im_req),  32'd1);
    check("restart_addr", 32'(bus.im_addr), 32'h00);

    // ---------------- zero-wait program {02 K=5, 04, 7F} ----------------
    // Memory always acks; acks outside FETCH must be ignored.
    for (int c = 1; c <= 10; c++) begin
      bus.im_ack  = 1'b1;
      bus.im_data = prog[bus.im_addr[1:0]];
      #1;
      check($sformatf("prog_exec_c%0d", c), 32'(bus.exec_en), 32'((c == 3) || (c == 6)));
      check($sformatf("prog_halt_c%0d", c), 32'(bus.halted), 32'(c >= 9));
      tick();
    end
    bus.im_ack = 1'b0;
    check("halt_pc", 32'(bus.pc), 32'h02);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("halt_start_ign", 32'(bus.halted), 32'd1);
    check("halt_no_req",    32'(bus.im_req), 32'd0);

    // ---------------- im_ack delayed 4 cycles ----------------
    do_reset();
    check("rst2_halted", 32'(bus.halted), 32'd0);
    bus.start = 1'b1;
    tick();
    bus.start   = 1'b0;
    bus.im_data = w(7'h02, 8'h09);
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("wait_req_c%0d", c), 32'(bus.im_req), 32'd1);
      check($sformatf("wait_ir_c%0d", c),  32'(bus.opcode), 32'h00);
      tick();
    end
    bus.im_ack = 1'b1;
    #1;
    check("wait_req_c5", 32'(bus.im_req), 32'd1);
    tick();                                   // DECODE
    bus.im_ack = 1'b0;
    check("wait_op",  32'(bus.opcode),  32'h02);
    check("wait_lit", 32'(bus.literal), 32'h09);
    check("wait_dec_exec", 32'(bus.exec_en), 32'd0);
    tick();
    check("wait_exec", 32'(bus.exec_en), 32'd1);
    tick();
    check("wait_exec_off", 32'(bus.exec_en), 32'd0);
    check("wait_pc", 32'(bus.im_addr), 32'h01);

    // ---------------- jumps ----------------
    run_instr("alu_z1", 7'h04, 8'h00, 4'b0001, 1'b1, 1'b1);
    check("alu_z1_pc", 32'(bus.im_addr), 32'h02);
    bus.status = 4'b0000;                      // live Z=0 must not matter
    run_instr("jeq_t", 7'h49, 8'h40, 4'b0000, 1'b0, 1'b0);
    check("jeq_t_pc", 32'(bus.im_addr), 32'h40);
    run_instr("alu_z0", 7'h04, 8'h00, 4'b0000, 1'b0, 1'b1);
    check("alu_z0_pc", 32'(bus.im_addr), 32'h41);
    bus.status = 4'b0001;                      // live Z=1 must not matter
    run_instr("jeq_nt", 7'h49, 8'h40, 4'b0001, 1'b0, 1'b0);
    check("jeq_nt_pc", 32'(bus.im_addr), 32'h42);
    run_instr("jne_t", 7'h4A, 8'h80, 4'b0001, 1'b0, 1'b0);
    check("jne_t_pc", 32'(bus.im_addr), 32'h80);
    run_instr("jmp", 7'h48, 8'hFF, 4'b0000, 1'b0, 1'b0);
    check("jmp_pc", 32'(bus.im_addr), 32'hFF);

    // ---------------- pc wrap, sets C ----------------
    run_instr("alu_wrap", 7'h02, 8'h00, 4'b0100, 1'b1, 1'b1);
    check("wrap_pc", 32'(bus.im_addr), 32'h00);

    // ---------------- MEM 0x28, dm_ack on third cycle ----------------
    bus.im_data = w(7'h28, 8'h33);
    bus.im_ack  = 1'b1;
    tick();                                   // DECODE
    bus.im_ack  = 1'b0;
    bus.dm_ack  = 1'b1;                        // spurious, outside MEM
    #1;
    check("mem_dec_op",  32'(bus.opcode), 32'h28);
    check("mem_dec_req", 32'(bus.dm_req), 32'd0);
    tick();                                   // MEM cycle 1
    bus.dm_ack = 1'b0;
    bus.status = 4'b0000;
    #1;
    check("mem_c1_req",  32'(bus.dm_req),  32'd1);
    check("mem_c1_exec", 32'(bus.exec_en), 32'd0);
    tick();                                   // MEM cycle 2
    check("mem_c2_req",  32'(bus.dm_req),  32'd1);
    check("mem_c2_exec", 32'(bus.exec_en), 32'd0);
    tick();                                   // MEM cycle 3
    bus.dm_ack = 1'b1;
    #1;
    check("mem_c3_req",  32'(bus.dm_req),  32'd1);
    check("mem_c3_exec", 32'(bus.exec_en), 32'd1);
    tick();                                   // FETCH
    bus.dm_ack = 1'b0;
    #1;
    check("mem_done_req",  32'(bus.dm_req),  32'd0);
    check("mem_done_exec", 32'(bus.exec_en), 32'd0);
    check("mem_pc",        32'(bus.im_addr), 32'h01);

    // Flags still hold C=1 from the ALU before the MEM access.
    run_instr("jcs_t", 7'h4B, 8'h10, 4'b0000, 1'b0, 1'b0);
    check("jcs_t_pc", 32'(bus.im_addr), 32'h10);
    run_instr("jx_nt", 7'h4C, 8'h20, 4'b0000, 1'b1, 1'b0);
    check("jx_nt_pc", 32'(bus.im_addr), 32'h11);
    run_instr("nop", 7'h60, 8'h00, 4'b0000, 1'b0, 1'b1);
    check("nop_pc", 32'(bus.im_addr), 32'h12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
